// File: rtl/vga_fb_scanout_pkg.sv
// Shared constants, colour bus type and helpers for the frame-buffer VGA scanout.
package vga_fb_scanout_pkg;

  localparam int unsigned CLK_DIV_DEF = 2;
  localparam int unsigned H_VIS_DEF   = 640;
  localparam int unsigned H_FP_DEF    = 16;
  localparam int unsigned H_SYNC_DEF  = 96;
  localparam int unsigned H_BP_DEF    = 48;
  localparam int unsigned V_VIS_DEF   = 480;
  localparam int unsigned V_FP_DEF    = 10;
  localparam int unsigned V_SYNC_DEF  = 2;
  localparam int unsigned V_BP_DEF    = 33;

  localparam int unsigned FB_WIDTH    = 160;
  localparam int unsigned FB_HEIGHT   = 120;
  localparam int unsigned FB_ADDR_W   = 15;
  localparam int unsigned COLOR_W     = 3;
  localparam int unsigned DAC_W       = 8;
  localparam int unsigned PIX_SHIFT   = 2;
  localparam int unsigned CNT_W       = 10;
  localparam int unsigned FB_X_W      = CNT_W - PIX_SHIFT;
  localparam int unsigned FB_Y_W      = CNT_W - 1 - PIX_SHIFT;

  // 160 = 128 + 32, so y*160 is built from two shifts
  localparam int unsigned ROW_SH_HI   = 7;
  localparam int unsigned ROW_SH_LO   = 5;

  typedef struct packed {
    logic [DAC_W-1:0] r;
    logic [DAC_W-1:0] g;
    logic [DAC_W-1:0] b;
  } rgb_t;

  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_Y_W-1:0] y,
                                                   input logic [FB_X_W-1:0] x);
    logic [FB_ADDR_W-1:0] row;
    row = FB_ADDR_W'(y);
    return (row << ROW_SH_HI) + (row << ROW_SH_LO) + FB_ADDR_W'(x);
  endfunction

  function automatic rgb_t expand_color(input logic [COLOR_W-1:0] c);
    rgb_t o;
    o.r = {DAC_W{c[2]}};
    o.g = {DAC_W{c[1]}};
    o.b = {DAC_W{c[0]}};
    return o;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-tick divider, raster counters and the combinational sync/visible decode.
module vga_timing_counter
  import vga_fb_scanout_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned H_VIS   = H_VIS_DEF,
  parameter int unsigned H_FP    = H_FP_DEF,
  parameter int unsigned H_SYNC  = H_SYNC_DEF,
  parameter int unsigned H_BP    = H_BP_DEF,
  parameter int unsigned V_VIS   = V_VIS_DEF,
  parameter int unsigned V_FP    = V_FP_DEF,
  parameter int unsigned V_SYNC  = V_SYNC_DEF,
  parameter int unsigned V_BP    = V_BP_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic              tick_c_o,
  output logic [FB_X_W-1:0] fb_x_o,
  output logic [FB_Y_W-1:0] fb_y_o,
  output logic              visible_c_o,
  output logic              hsync_c_o,
  output logic              vsync_c_o,
  output logic              frame_start_o,
  output logic              vga_clk_o
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             frame_start_q, frame_start_d;
  logic             vga_clk_q, vga_clk_d;
  logic             tick;
  logic             h_last, v_last;

  assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
  assign h_last = (hcount_q == CNT_W'(H_TOT - 1));
  assign v_last = (vcount_q == CNT_W'(V_TOT - 1));

  always_comb begin
    div_d         = tick ? '0 : div_q + DIV_W'(1);
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    // VGA_CLK rises mid-tick, half a tick after the pins change
    vga_clk_d     = (div_d >= DIV_W'(CLK_DIV / 2));
    frame_start_d = tick && h_last && (vcount_q == CNT_W'(V_VIS - 1));
    if (tick) begin
      if (h_last) begin
        hcount_d = '0;
        vcount_d = v_last ? '0 : vcount_q + CNT_W'(1);
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
      vga_clk_q     <= vga_clk_d;
    end
  end

  assign tick_c_o      = tick;
  assign fb_x_o        = hcount_q[CNT_W-1:PIX_SHIFT];
  assign fb_y_o        = vcount_q[CNT_W-2:PIX_SHIFT];
  assign visible_c_o   = (hcount_q < CNT_W'(H_VIS)) && (vcount_q < CNT_W'(V_VIS));
  assign hsync_c_o     = (hcount_q >= CNT_W'(H_VIS + H_FP)) &&
                         (hcount_q <  CNT_W'(H_VIS + H_FP + H_SYNC));
  assign vsync_c_o     = (vcount_q >= CNT_W'(V_VIS + V_FP)) &&
                         (vcount_q <  CNT_W'(V_VIS + V_FP + V_SYNC));
  assign frame_start_o = frame_start_q;
  assign vga_clk_o     = vga_clk_q;

endmodule

// File: rtl/vga_fb_scanout.sv
// Frame-buffer scanout: address generation and the two-stage colour/sync pipeline to the DAC.
module vga_fb_scanout
  import vga_fb_scanout_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned H_VIS   = H_VIS_DEF,
  parameter int unsigned H_FP    = H_FP_DEF,
  parameter int unsigned H_SYNC  = H_SYNC_DEF,
  parameter int unsigned H_BP    = H_BP_DEF,
  parameter int unsigned V_VIS   = V_VIS_DEF,
  parameter int unsigned V_FP    = V_FP_DEF,
  parameter int unsigned V_SYNC  = V_SYNC_DEF,
  parameter int unsigned V_BP    = V_BP_DEF
) (
  input  logic                 clock,
  input  logic                 resetn,
  output logic [FB_ADDR_W-1:0] rd_addr,
  input  logic [COLOR_W-1:0]   rd_data,
  output logic                 VGA_CLK,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_N,
  output logic [DAC_W-1:0]     VGA_R,
  output logic [DAC_W-1:0]     VGA_G,
  output logic [DAC_W-1:0]     VGA_B,
  output logic                 frame_start
);

  logic              tick, visible_c, hsync_c, vsync_c;
  logic [FB_X_W-1:0] fb_x;
  logic [FB_Y_W-1:0] fb_y;

  vga_timing_counter #(
    .CLK_DIV (CLK_DIV), .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS   (V_VIS),   .V_FP  (V_FP),  .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk_i         (clock),
    .rst_n_i       (resetn),
    .tick_c_o      (tick),
    .fb_x_o        (fb_x),
    .fb_y_o        (fb_y),
    .visible_c_o   (visible_c),
    .hsync_c_o     (hsync_c),
    .vsync_c_o     (vsync_c),
    .frame_start_o (frame_start),
    .vga_clk_o     (VGA_CLK)
  );

  logic [FB_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic                 vis_q, hs_n_q, vs_n_q;
  logic                 hs_out_q, vs_out_q, blank_n_q;
  rgb_t                 rgb_q, rgb_d;

  // Address freezes outside the visible window so the RAM sees a stable, known value
  always_comb begin
    rd_addr_d = rd_addr_q;
    rgb_d     = '0;
    if (visible_c) rd_addr_d = fb_addr(fb_y, fb_x);
    if (vis_q)     rgb_d     = expand_color(rd_data);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_addr_q <= '0;
      vis_q     <= 1'b0;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      hs_out_q  <= 1'b1;
      vs_out_q  <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else if (tick) begin
      rd_addr_q <= rd_addr_d;
      vis_q     <= visible_c;
      hs_n_q    <= ~hsync_c;
      vs_n_q    <= ~vsync_c;
      hs_out_q  <= hs_n_q;
      vs_out_q  <= vs_n_q;
      blank_n_q <= vis_q;
      rgb_q     <= rgb_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign VGA_HS      = hs_out_q;
  assign VGA_VS      = vs_out_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = rgb_q.r;
  assign VGA_G       = rgb_q.g;
  assign VGA_B       = rgb_q.b;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout on a shrunken raster (96x48 ticks) with a 1-clock RAM model.
module tb_vga_fb_scanout;

  localparam int unsigned H_TOT = 96;
  localparam int unsigned V_TOT = 48;
  localparam int unsigned FRAME = H_TOT * V_TOT;
  localparam int unsigned NVEC  = 25;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  bit          ram_ones = 1'b0;

  int checks = 0;
  int errors = 0;

  vga_fb_scanout #(
    .CLK_DIV (2), .H_VIS (64), .H_FP (8), .H_SYNC (16), .H_BP (8),
    .V_VIS   (40), .V_FP (3), .V_SYNC (2), .V_BP (3)
  ) dut (
    .clock       (clk),
    .resetn      (resetn),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ram_val(input logic [14:0] a);
    if (a == 15'd1284) return 3'b101;
    return a[2:0];
  endfunction

  always @(posedge clk) rd_data <= ram_ones ? 3'b111 : ram_val(rd_addr);

  int unsigned edge_n = 0;
  always @(posedge clk or negedge resetn)
    if (!resetn) edge_n <= 0;
    else         edge_n <= edge_n + 1;

  // Transition log for period/width checks
  int unsigned fs_cnt = 0, fs_hi = 0, hsf_n = 0, hsr_n = 0, vsf_n = 0, vsr_n = 0;
  int unsigned fs_e0 = 0, fs_e1 = 0, hsf_e0 = 0, hsf_e1 = 0, hsr_e0 = 0, vsf_e0 = 0, vsr_e0 = 0;
  logic fs_prev = 1'b0, hs_prev = 1'b1, vs_prev = 1'b1;
  always @(negedge clk) begin
    if (resetn) begin
      if (frame_start) begin
        fs_hi++;
        if (!fs_prev) begin
          if (fs_cnt == 0) fs_e0 = edge_n;
          if (fs_cnt == 1) fs_e1 = edge_n;
          fs_cnt++;
        end
      end
      if (hs_prev && !VGA_HS) begin
        if (hsf_n == 0) hsf_e0 = edge_n;
        if (hsf_n == 1) hsf_e1 = edge_n;
        hsf_n++;
      end
      if (!hs_prev && VGA_HS) begin
        if (hsr_n == 0) hsr_e0 = edge_n;
        hsr_n++;
      end
      if (vs_prev && !VGA_VS) begin
        if (vsf_n == 0) vsf_e0 = edge_n;
        vsf_n++;
      end
      if (!vs_prev && VGA_VS) begin
        if (vsr_n == 0) vsr_e0 = edge_n;
        vsr_n++;
      end
      fs_prev = frame_start;
      hs_prev = VGA_HS;
      vs_prev = VGA_VS;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to #1 after posedge number 'target' since the last reset release
  task automatic wait_edge(input int unsigned target);
    int unsigned guard = 0;
    while (edge_n < target && guard < 40000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (edge_n != target) chk("edge alignment", 32'(edge_n), 32'(target));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " VGA_HS"},      32'(VGA_HS), 32'd1);
    chk({tag, " VGA_VS"},      32'(VGA_VS), 32'd1);
    chk({tag, " VGA_BLANK_N"}, 32'(VGA_BLANK_N), 32'd0);
    chk({tag, " RGB"},         32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    chk({tag, " rd_addr"},     32'(rd_addr), 32'd0);
    chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, " VGA_CLK"},     32'(VGA_CLK), 32'd0);
  endtask

  typedef struct {
    int unsigned f, h, v;
    bit          ones;
    logic [14:0] addr;
    logic        hs, vs, bn;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[NVEC];

  initial begin
    //          f  h   v  ones  rd_addr   hs    vs    bn    rgb
    vecs[0]  = '{0, 0,  0, 1'b0, 15'd0,    1'b1, 1'b1, 1'b1, 24'h000000};
    vecs[1]  = '{0, 5,  0, 1'b0, 15'd1,    1'b1, 1'b1, 1'b1, 24'h0000FF};
    vecs[2]  = '{0, 63, 0, 1'b0, 15'd15,   1'b1, 1'b1, 1'b1, 24'hFFFFFF};
    vecs[3]  = '{0, 64, 0, 1'b0, 15'd15,   1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[4]  = '{0, 71, 0, 1'b0, 15'd15,   1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[5]  = '{0, 72, 0, 1'b0, 15'd15,   1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[6]  = '{0, 87, 0, 1'b0, 15'd15,   1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[7]  = '{0, 88, 0, 1'b0, 15'd15,   1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[8]  = '{0, 95, 0, 1'b0, 15'd15,   1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[9]  = '{0, 6,  5, 1'b0, 15'd161,  1'b1, 1'b1, 1'b1, 24'h0000FF};
    vecs[10] = '{0, 15, 33, 1'b0, 15'd1283, 1'b1, 1'b1, 1'b1, 24'h00FFFF};
    vecs[11] = '{0, 17, 33, 1'b0, 15'd1284, 1'b1, 1'b1, 1'b1, 24'hFF00FF};
    vecs[12] = '{0, 18, 33, 1'b0, 15'd1284, 1'b1, 1'b1, 1'b1, 24'hFF00FF};
    vecs[13] = '{0, 19, 33, 1'b0, 15'd1284, 1'b1, 1'b1, 1'b1, 24'hFF00FF};
    vecs[14] = '{0, 63, 39, 1'b0, 15'd1455, 1'b1, 1'b1, 1'b1, 24'hFFFFFF};
    vecs[15] = '{0, 0,  40, 1'b0, 15'd1455, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[16] = '{0, 10, 42, 1'b0, 15'd1455, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[17] = '{0, 10, 43, 1'b0, 15'd1455, 1'b1, 1'b0, 1'b0, 24'h000000};
    vecs[18] = '{0, 80, 44, 1'b0, 15'd1455, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[19] = '{0, 0,  45, 1'b0, 15'd1455, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[20] = '{0, 95, 47, 1'b0, 15'd1455, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[21] = '{1, 1,  0, 1'b1, 15'd0,    1'b1, 1'b1, 1'b1, 24'hFFFFFF};
    vecs[22] = '{1, 63, 1, 1'b1, 15'd15,   1'b1, 1'b1, 1'b1, 24'hFFFFFF};
    vecs[23] = '{1, 64, 1, 1'b1, 15'd15,   1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[24] = '{1, 30, 41, 1'b1, 15'd1455, 1'b1, 1'b1, 1'b0, 24'h000000};

    #12;
    chk_reset_vals("in reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      int unsigned p;
      p = vecs[i].f * FRAME + vecs[i].v * H_TOT + vecs[i].h;
      ram_ones = vecs[i].ones;
      wait_edge(2 * (p + 1));
      chk($sformatf("vec%0d rd_addr", i), 32'(rd_addr), 32'(vecs[i].addr));
      wait_edge(2 * (p + 2));
      chk($sformatf("vec%0d VGA_HS", i),      32'(VGA_HS),      32'(vecs[i].hs));
      chk($sformatf("vec%0d VGA_VS", i),      32'(VGA_VS),      32'(vecs[i].vs));
      chk($sformatf("vec%0d VGA_BLANK_N", i), 32'(VGA_BLANK_N), 32'(vecs[i].bn));
      chk($sformatf("vec%0d RGB", i),         32'({VGA_R, VGA_G, VGA_B}), 32'(vecs[i].rgb));
    end

    chk("frame_start pulses", 32'(fs_cnt), 32'd2);
    chk("frame_start high clocks", 32'(fs_hi), 32'd2);
    chk("frame_start first edge", 32'(fs_e0), 32'd7680);
    chk("frame_start second edge", 32'(fs_e1), 32'd16896);
    chk("hsync first fall", 32'(hsf_e0), 32'd148);
    chk("hsync second fall", 32'(hsf_e1), 32'd340);
    chk("hsync first rise", 32'(hsr_e0), 32'd180);
    chk("vsync first fall", 32'(vsf_e0), 32'd8260);
    chk("vsync first rise", 32'(vsr_e0), 32'd8644);

    // Async reset mid-line on a visible pixel of frame 2, line 1
    wait_edge(2 * (2 * FRAME + H_TOT + 30));
    chk("pre-reset BLANK_N", 32'(VGA_BLANK_N), 32'd1);
    chk("pre-reset RGB", 32'({VGA_R, VGA_G, VGA_B}), 32'hFFFFFF);
    chk("pre-reset rd_addr", 32'(rd_addr), 32'd7);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_vals("async reset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    wait_edge(4);
    chk("restart BLANK_N", 32'(VGA_BLANK_N), 32'd1);
    chk("restart RGB", 32'({VGA_R, VGA_G, VGA_B}), 32'hFFFFFF);
    wait_edge(12);
    chk("restart rd_addr", 32'(rd_addr), 32'd1);
    wait_edge(146);
    chk("restart hsync before", 32'(VGA_HS), 32'd1);
    wait_edge(148);
    chk("restart hsync start", 32'(VGA_HS), 32'd0);
    wait_edge(200);
    chk("VGA_CLK first half", 32'(VGA_CLK), 32'd0);
    wait_edge(201);
    chk("VGA_CLK second half", 32'(VGA_CLK), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
